secded_64_57_decoder: RTL

// - Pipelined SEC-DED decoder for 64-bit Hamming(64,57) codewords. Sits directly downstream of the single-bit error-injection stage.
// - Corrects any single-bit error, flags any double-bit error, and returns the 57 data bits.
// - Keeps saturating counts of corrected and uncorrectable words for the test harness.

---
 rtl/secded_64_57_decoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/secded_64_57_decoder.sv
// rtl/secded_64_57_decoder.sv - two-stage Hamming(64,57) SEC-DED decoder with saturating error counters
// Optional sticky first-error log enabled by defining SECDED_ERR_LOG_EN.
module secded_64_57_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [56:0]      out_data,
  output logic             out_sbe,
  output logic             out_dbe,
  output logic [5:0]       out_syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_sbe,
  output logic [CNT_W-1:0] cnt_dbe,
  output logic             err_log_vld,
  output logic [7:0]       err_log
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        en;
  logic        hs;
  logic        s1_valid;
  logic [63:0] s1_code;
  logic [5:0]  s1_syn;
  logic        s1_par;
  logic [63:0] fix_code;
  logic        sbe_n;
  logic        dbe_n;

  function automatic logic [5:0] calc_syn(input logic [63:0] c);
    logic [5:0] s;
    s = '0;
    for (int i = 1; i < 64; i++) begin
      if (c[i]) s = s ^ 6'(i);
    end
    return s;
  endfunction

  // Data occupies every non-power-of-two position from 3 upward, in order.
  function automatic logic [56:0] extract(input logic [63:0] c);
    logic [56:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int i = 3; i < 64; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  // One global advance: a stalled output freezes the whole pipe, bubbles included.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign hs       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_code  <= in_code;
      s1_syn   <= calc_syn(in_code);
      s1_par   <= ^in_code;
    end
  end

  // Odd overall parity means one flip (syndrome 0 -> the parity bit itself).
  always_comb begin
    fix_code = s1_code;
    if (s1_par && (s1_syn != 6'd0)) fix_code[s1_syn] = ~s1_code[s1_syn];
    sbe_n = s1_par;
    dbe_n = ~s1_par & (s1_syn != 6'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sbe      <= 1'b0;
      out_dbe      <= 1'b0;
      out_syndrome <= '0;
    end else if (en) begin
      out_valid    <= s1_valid;
      out_data     <= extract(fix_code);
      out_sbe      <= sbe_n;
      out_dbe      <= dbe_n;
      out_syndrome <= s1_syn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_sbe <= '0;
      cnt_dbe <= '0;
    end else if (hs) begin
      if (out_sbe && (cnt_sbe != CNT_MAX)) cnt_sbe <= cnt_sbe + 1'b1;
      if (out_dbe && (cnt_dbe != CNT_MAX)) cnt_dbe <= cnt_dbe + 1'b1;
    end
  end

`ifdef SECDED_ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_log_vld <= 1'b0;
      err_log     <= '0;
    end else if (hs && (out_sbe || out_dbe) && !err_log_vld) begin
      err_log_vld <= 1'b1;
      err_log     <= {out_dbe, out_sbe, out_syndrome};
    end
  end
`else
  assign err_log_vld = 1'b0;
  assign err_log     = 8'h00;
`endif

endmodule
